// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS main control: opcodes,
// ALUOP encodings seen by the ALU control decoder, FSM states and the
// combinational control bundle.
package mips_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'd0;
   localparam logic [5:0] OP_LW    = 6'd35;
   localparam logic [5:0] OP_SW    = 6'd43;
   localparam logic [5:0] OP_BEQ   = 6'd4;
   localparam logic [5:0] OP_BNE   = 6'd5;
   localparam logic [5:0] OP_ADDI  = 6'd8;
   localparam logic [5:0] OP_ANDI  = 6'd12;
   localparam logic [5:0] OP_ORI   = 6'd13;
   localparam logic [5:0] OP_J     = 6'd2;

   localparam logic [2:0] ALUOP_ADD   = 3'b000;
   localparam logic [2:0] ALUOP_BEQ   = 3'b001;
   localparam logic [2:0] ALUOP_BNE   = 3'b111;
   localparam logic [2:0] ALUOP_AND   = 3'b011;
   localparam logic [2:0] ALUOP_OR    = 3'b100;
   localparam logic [2:0] ALUOP_RTYPE = 3'b010;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMRD    = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWR    = 4'd5,
      S_RTYPE_EX = 4'd6,
      S_RTYPE_WB = 4'd7,
      S_BRANCH   = 4'd8,
      S_JUMP     = 4'd9,
      S_IMM_EX   = 4'd10,
      S_IMM_WB   = 4'd11
   } state_t;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       ir_write;
      logic       reg_write;
      logic       reg_dst;
      logic       alu_src_a;
      logic       zext;
      logic [1:0] alu_src_b;
      logic [1:0] pc_source;
      logic [2:0] alu_op;
      logic       instr_done;
   } ctrl_t;

   // True for every opcode the FSM knows how to sequence.
   function automatic logic op_is_legal(input logic [5:0] op);
      return (op == OP_RTYPE) || (op == OP_LW)   || (op == OP_SW)   ||
             (op == OP_BEQ)   || (op == OP_BNE)  || (op == OP_ADDI) ||
             (op == OP_ANDI)  || (op == OP_ORI)  || (op == OP_J);
   endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Pure combinational map from {state, opcode, mem_ready} to the datapath
// control bundle (Moore outputs, plus the mem_ready-qualified strobes).
module mc_ctrl_decode
   import mips_ctrl_pkg::*;
(
   input  state_t      state_i,
   input  logic [5:0]  opcode,
   input  logic        mem_ready,
   output ctrl_t       ctrl
);

   logic is_logic_imm;
   assign is_logic_imm = (opcode == OP_ANDI) || (opcode == OP_ORI);

   // Per-state output decode; anything not set for a state stays 0.
   always_comb begin
      ctrl = '0;
      unique case (state_i)
         S_FETCH: begin
            ctrl.mem_read  = 1'b1;
            ctrl.alu_src_b = 2'b01;
            ctrl.alu_op    = ALUOP_ADD;
            ctrl.ir_write  = mem_ready;
            ctrl.pc_write  = mem_ready;
         end
         S_DECODE: begin
            ctrl.alu_src_b = 2'b11;
            ctrl.alu_op    = ALUOP_ADD;
         end
         S_MEMADR: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = 2'b10;
            ctrl.alu_op    = ALUOP_ADD;
         end
         S_MEMRD: begin
            ctrl.mem_read = 1'b1;
            ctrl.i_or_d   = 1'b1;
         end
         S_MEMWB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = 1'b1;
            ctrl.instr_done = 1'b1;
         end
         S_MEMWR: begin
            ctrl.mem_write  = 1'b1;
            ctrl.i_or_d     = 1'b1;
            ctrl.instr_done = mem_ready;
         end
         S_RTYPE_EX: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_op    = ALUOP_RTYPE;
         end
         S_RTYPE_WB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.reg_dst    = 1'b1;
            ctrl.instr_done = 1'b1;
         end
         S_BRANCH: begin
            ctrl.alu_src_a     = 1'b1;
            ctrl.pc_write_cond = 1'b1;
            ctrl.pc_source     = 2'b01;
            ctrl.instr_done    = 1'b1;
            ctrl.alu_op        = (opcode == OP_BNE) ? ALUOP_BNE : ALUOP_BEQ;
         end
         S_JUMP: begin
            ctrl.pc_write   = 1'b1;
            ctrl.pc_source  = 2'b10;
            ctrl.instr_done = 1'b1;
         end
         S_IMM_EX: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = 2'b10;
            ctrl.zext      = is_logic_imm;
            if (opcode == OP_ANDI)     ctrl.alu_op = ALUOP_AND;
            else if (opcode == OP_ORI) ctrl.alu_op = ALUOP_OR;
            else                       ctrl.alu_op = ALUOP_ADD;
         end
         S_IMM_WB: begin
            // zext stays up so the write-back sees the same immediate extension
            ctrl.reg_write  = 1'b1;
            ctrl.instr_done = 1'b1;
            ctrl.zext       = is_logic_imm;
         end
         default: ctrl = '0;
      endcase
   end

endmodule

// File: rtl/mc_main_control.sv
// Multicycle MIPS main control: state register, next-state logic and the
// illegal-opcode pulse; output decode lives in mc_ctrl_decode.
module mc_main_control
   import mips_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       MemtoReg,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic       RegDst,
   output logic       ALUSrcA,
   output logic       zext,
   output logic [1:0] ALUSrcB,
   output logic [1:0] PCSource,
   output logic [2:0] ALUOP,
   output logic [3:0] state_o,
   output logic       instr_done,
   output logic       illegal_op
);

   state_t state_q, state_d;
   logic   illegal_op_q, illegal_op_d;
   ctrl_t  ctrl_raw, ctrl;

   // State and illegal-opcode flops, cleared asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_FETCH;
         illegal_op_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         illegal_op_q <= illegal_op_d;
      end
   end

   // Next-state sequencing; mem_ready only matters in the memory-wait states.
   always_comb begin
      state_d      = state_q;
      illegal_op_d = 1'b0;
      unique case (state_q)
         S_FETCH:  if (mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            if ((opcode == OP_LW) || (opcode == OP_SW))        state_d = S_MEMADR;
            else if (opcode == OP_RTYPE)                       state_d = S_RTYPE_EX;
            else if ((opcode == OP_BEQ) || (opcode == OP_BNE)) state_d = S_BRANCH;
            else if (opcode == OP_J)                           state_d = S_JUMP;
            else if ((opcode == OP_ADDI) || (opcode == OP_ANDI) ||
                     (opcode == OP_ORI))                       state_d = S_IMM_EX;
            else                                               state_d = S_FETCH;
            illegal_op_d = !op_is_legal(opcode);
         end
         S_MEMADR: begin
            if (opcode == OP_LW)      state_d = S_MEMRD;
            else if (opcode == OP_SW) state_d = S_MEMWR;
            else                      state_d = S_FETCH;
         end
         S_MEMRD:    if (mem_ready) state_d = S_MEMWB;
         S_MEMWR:    if (mem_ready) state_d = S_FETCH;
         S_RTYPE_EX: state_d = S_RTYPE_WB;
         S_IMM_EX:   state_d = S_IMM_WB;
         default:    state_d = S_FETCH;
      endcase
   end

   mc_ctrl_decode u_decode (
      .state_i   (state_q),
      .opcode    (opcode),
      .mem_ready (mem_ready),
      .ctrl      (ctrl_raw)
   );

   // Reset forces every strobe low immediately, even though FETCH would drive MemRead.
   always_comb begin
      ctrl = rst ? '0 : ctrl_raw;
   end

   assign PCWrite     = ctrl.pc_write;
   assign PCWriteCond = ctrl.pc_write_cond;
   assign IorD        = ctrl.i_or_d;
   assign MemRead     = ctrl.mem_read;
   assign MemWrite    = ctrl.mem_write;
   assign MemtoReg    = ctrl.mem_to_reg;
   assign IRWrite     = ctrl.ir_write;
   assign RegWrite    = ctrl.reg_write;
   assign RegDst      = ctrl.reg_dst;
   assign ALUSrcA     = ctrl.alu_src_a;
   assign zext        = ctrl.zext;
   assign ALUSrcB     = ctrl.alu_src_b;
   assign PCSource    = ctrl.pc_source;
   assign ALUOP       = ctrl.alu_op;
   assign instr_done  = ctrl.instr_done;
   assign state_o     = state_q;
   assign illegal_op  = illegal_op_q;

endmodule

// File: tb/tb_mc_main_control.sv
// Directed bench for mc_main_control: walks each instruction class cycle by
// cycle and compares outputs against hand-derived values.
module tb_mc_main_control;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] opcode;
   logic       mem_ready;
   logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
   logic       IRWrite, RegWrite, RegDst, ALUSrcA, zext, instr_done, illegal_op;
   logic [1:0] ALUSrcB, PCSource;
   logic [2:0] ALUOP;
   logic [3:0] state_o;

   int checks = 0;
   int errors = 0;

   mc_main_control dut (
      .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
      .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
      .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst),
      .ALUSrcA(ALUSrcA), .zext(zext), .ALUSrcB(ALUSrcB),
      .PCSource(PCSource), .ALUOP(ALUOP), .state_o(state_o),
      .instr_done(instr_done), .illegal_op(illegal_op)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance to the next sampling point and check the state.
   task automatic step(input string tag, input int exp_state);
      @(negedge clk);
      check(tag, int'(state_o), exp_state);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; opcode = 6'd35; mem_ready = 1'b0;
      @(negedge clk); @(negedge clk);
      check("rst_state",   int'(state_o), 0);
      check("rst_memread", int'(MemRead), 0);
      check("rst_alusrcb", int'(ALUSrcB), 0);
      check("rst_illegal", int'(illegal_op), 0);

      // Release reset; FETCH outputs appear at once, stalled by mem_ready = 0.
      rst = 1'b0; #1;
      check("fetch_state",   int'(state_o), 0);
      check("fetch_memread", int'(MemRead), 1);
      check("fetch_irw_stl", int'(IRWrite), 0);
      step("fetch_stall", 0);
      check("fetch_pcw_stl", int'(PCWrite), 0);
      mem_ready = 1'b1; #1;
      check("fetch_irw",    int'(IRWrite), 1);
      check("fetch_pcw",    int'(PCWrite), 1);
      check("fetch_srcb",   int'(ALUSrcB), 1);

      // lw: 0,1,2,3,4
      step("lw_dec", 1);
      check("lw_dec_srcb", int'(ALUSrcB), 3);
      check("lw_dec_done", int'(instr_done), 0);
      step("lw_adr", 2);
      check("lw_adr_srca", int'(ALUSrcA), 1);
      check("lw_adr_srcb", int'(ALUSrcB), 2);
      step("lw_rd", 3);
      check("lw_rd_iord",  int'(IorD), 1);
      check("lw_rd_mrd",   int'(MemRead), 1);
      check("lw_rd_regw",  int'(RegWrite), 0);
      step("lw_wb", 4);
      check("lw_wb_regw",  int'(RegWrite), 1);
      check("lw_wb_m2r",   int'(MemtoReg), 1);
      check("lw_wb_done",  int'(instr_done), 1);
      step("lw_end", 0);
      check("lw_end_done", int'(instr_done), 0);
      check("lw_end_regw", int'(RegWrite), 0);

      // sw with three stall cycles in MEMWR: 7 cycles total.
      opcode = 6'd43;
      step("sw_dec", 1);
      step("sw_adr", 2);
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step("sw_wr_stall", 5);
         check("sw_wr_mw",   int'(MemWrite), 1);
         check("sw_wr_done", int'(instr_done), 0);
      end
      @(posedge clk); #1 mem_ready = 1'b1;
      step("sw_wr_last", 5);
      check("sw_wr_mw4",   int'(MemWrite), 1);
      check("sw_wr_done4", int'(instr_done), 1);
      step("sw_end", 0);
      check("sw_end_mw", int'(MemWrite), 0);

      // R-type
      opcode = 6'd0;
      step("r_dec", 1);
      step("r_ex", 6);
      check("r_ex_aluop", int'(ALUOP), 2);
      check("r_ex_srca",  int'(ALUSrcA), 1);
      step("r_wb", 7);
      check("r_wb_regdst", int'(RegDst), 1);
      check("r_wb_regw",   int'(RegWrite), 1);
      step("r_end", 0);

      // bne
      opcode = 6'd5;
      step("bne_dec", 1);
      step("bne_br", 8);
      check("bne_aluop", int'(ALUOP), 7);
      check("bne_pwc",   int'(PCWriteCond), 1);
      check("bne_pcsrc", int'(PCSource), 1);
      check("bne_done",  int'(instr_done), 1);
      step("bne_end", 0);

      // beq
      opcode = 6'd4;
      step("beq_dec", 1);
      step("beq_br", 8);
      check("beq_aluop", int'(ALUOP), 1);
      step("beq_end", 0);

      // andi
      opcode = 6'd12;
      step("andi_dec", 1);
      step("andi_ex", 10);
      check("andi_aluop", int'(ALUOP), 3);
      check("andi_zext",  int'(zext), 1);
      check("andi_srcb",  int'(ALUSrcB), 2);
      step("andi_wb", 11);
      check("andi_wb_zext", int'(zext), 1);
      check("andi_wb_regw", int'(RegWrite), 1);
      step("andi_end", 0);

      // ori and addi execute encodings
      opcode = 6'd13;
      step("ori_dec", 1);
      step("ori_ex", 10);
      check("ori_aluop", int'(ALUOP), 4);
      step("ori_wb", 11);
      step("ori_end", 0);
      opcode = 6'd8;
      step("addi_dec", 1);
      step("addi_ex", 10);
      check("addi_aluop", int'(ALUOP), 0);
      check("addi_zext",  int'(zext), 0);
      step("addi_wb", 11);
      check("addi_wb_zext", int'(zext), 0);
      step("addi_end", 0);

      // j
      opcode = 6'd2;
      step("j_dec", 1);
      step("j_jmp", 9);
      check("j_pcw",   int'(PCWrite), 1);
      check("j_pcsrc", int'(PCSource), 2);
      step("j_end", 0);

      // illegal opcode
      opcode = 6'd63;
      step("ill_dec", 1);
      check("ill_dec_flag", int'(illegal_op), 0);
      step("ill_fetch", 0);
      check("ill_flag",  int'(illegal_op), 1);
      check("ill_regw",  int'(RegWrite), 0);
      check("ill_mw",    int'(MemWrite), 0);
      check("ill_pwc",   int'(PCWriteCond), 0);
      opcode = 6'd35;
      step("ill_next", 1);
      check("ill_flag_off", int'(illegal_op), 0);

      // reset asserted in MEMRD
      step("rr_adr", 2);
      step("rr_rd", 3);
      rst = 1'b1; #1;
      check("rr_state",   int'(state_o), 0);
      check("rr_memread", int'(MemRead), 0);
      check("rr_iord",    int'(IorD), 0);
      step("rr_held", 0);
      check("rr_held_mr", int'(MemRead), 0);
      rst = 1'b0; #1;
      check("rr_rel_state", int'(state_o), 0);
      check("rr_rel_mr",    int'(MemRead), 1);
      step("rr_dec", 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
